// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: register/stage status in, stall/flush/forward controls out.
// The master modport is the pipeline side; the slave modport is the controller.
interface pipe_hazard_ctrl_if;
  logic [4:0]  ID_RA, ID_RB;
  logic        ID_USE_A, ID_USE_B;
  logic [4:0]  EX_RD, MEM_RD, WB_RD;
  logic        EX_RF_LE, MEM_RF_LE, WB_RF_LE;
  logic        EX_L, EX_BR_TAKEN, EX_NULLIFY;
  logic [31:0] EX_TA;

  logic        PC_LE, IF_ID_LE, IF_ID_CLR, CU_BUBBLE, TA_SEL;
  logic [31:0] PC_TARGET;
  logic [1:0]  FWD_A, FWD_B;
  logic [15:0] STALL_CNT, FLUSH_CNT;

  modport master (
    output ID_RA, ID_RB, ID_USE_A, ID_USE_B, EX_RD, MEM_RD, WB_RD,
           EX_RF_LE, MEM_RF_LE, WB_RF_LE, EX_L, EX_BR_TAKEN, EX_NULLIFY, EX_TA,
    input  PC_LE, IF_ID_LE, IF_ID_CLR, CU_BUBBLE, TA_SEL, PC_TARGET,
           FWD_A, FWD_B, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  ID_RA, ID_RB, ID_USE_A, ID_USE_B, EX_RD, MEM_RD, WB_RD,
           EX_RF_LE, MEM_RF_LE, WB_RF_LE, EX_L, EX_BR_TAKEN, EX_NULLIFY, EX_TA,
    output PC_LE, IF_ID_LE, IF_ID_CLR, CU_BUBBLE, TA_SEL, PC_TARGET,
           FWD_A, FWD_B, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW stall detection, branch redirect/flush, operand forwarding select.
// Define HAZ_FORWARDING_EN to enable forwarding (only load-use stalls); default stalls until writeback.
module pipe_hazard_ctrl (
  input  logic             clk,
  input  logic             Reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, PEND = 2'd2} state_t;

  state_t      state;
  logic [31:0] target_q;
  logic [15:0] stall_cnt, flush_cnt;
  logic        a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
  logic        raw, h, stall_evt, flush_evt;
  logic [1:0]  fwd_a, fwd_b;

  function automatic logic src_match(input logic use_r, input logic [4:0] r,
                                     input logic [4:0] rd, input logic le);
    return use_r && (r != 5'd0) && (r == rd) && le;
  endfunction

  assign a_ex  = src_match(hz.ID_USE_A, hz.ID_RA, hz.EX_RD,  hz.EX_RF_LE);
  assign a_mem = src_match(hz.ID_USE_A, hz.ID_RA, hz.MEM_RD, hz.MEM_RF_LE);
  assign a_wb  = src_match(hz.ID_USE_A, hz.ID_RA, hz.WB_RD,  hz.WB_RF_LE);
  assign b_ex  = src_match(hz.ID_USE_B, hz.ID_RB, hz.EX_RD,  hz.EX_RF_LE);
  assign b_mem = src_match(hz.ID_USE_B, hz.ID_RB, hz.MEM_RD, hz.MEM_RF_LE);
  assign b_wb  = src_match(hz.ID_USE_B, hz.ID_RB, hz.WB_RD,  hz.WB_RF_LE);

`ifdef HAZ_FORWARDING_EN
  // A load result is not available in EX, so a load in EX is skipped for forwarding.
  function automatic logic [1:0] fwd_sel(input logic ex, input logic mem,
                                         input logic wb, input logic ex_load);
    if (ex && !ex_load) return 2'b01;
    if (mem)            return 2'b10;
    if (wb)             return 2'b11;
    return 2'b00;
  endfunction

  assign raw   = hz.EX_L && (a_ex || b_ex);
  assign fwd_a = fwd_sel(a_ex, a_mem, a_wb, hz.EX_L);
  assign fwd_b = fwd_sel(b_ex, b_mem, b_wb, hz.EX_L);
`else
  assign raw   = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // While stalled, EX holds a bubble, so its nullify request no longer refers to the ID instruction.
  assign h = raw && ((state == STALL) || !hz.EX_NULLIFY);

  always_comb begin
    hz.PC_LE     = 1'b1;
    hz.IF_ID_LE  = 1'b1;
    hz.IF_ID_CLR = 1'b0;
    hz.CU_BUBBLE = 1'b0;
    hz.TA_SEL    = 1'b0;
    hz.PC_TARGET = (state == PEND) ? target_q : hz.EX_TA;
    hz.FWD_A     = fwd_a;
    hz.FWD_B     = fwd_b;
    stall_evt    = 1'b0;
    flush_evt    = 1'b0;
    if (Reset) begin
      hz.PC_LE     = 1'b0;
      hz.IF_ID_LE  = 1'b0;
      hz.IF_ID_CLR = 1'b1;
      hz.CU_BUBBLE = 1'b1;
      hz.PC_TARGET = 32'h0;
      hz.FWD_A     = 2'b00;
      hz.FWD_B     = 2'b00;
    end else if (h) begin
      hz.PC_LE     = 1'b0;
      hz.IF_ID_LE  = 1'b0;
      hz.CU_BUBBLE = 1'b1;
      stall_evt    = 1'b1;
    end else begin
      case (state)
        RUN: begin
          hz.CU_BUBBLE = hz.EX_NULLIFY;
          if (hz.EX_BR_TAKEN) begin
            hz.TA_SEL    = 1'b1;
            hz.IF_ID_CLR = 1'b1;
            flush_evt    = 1'b1;
          end
        end
        PEND: begin
          hz.TA_SEL    = 1'b1;
          hz.IF_ID_CLR = 1'b1;
          flush_evt    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= RUN;
      target_q  <= 32'h0;
      stall_cnt <= 16'h0;
      flush_cnt <= 16'h0;
    end else begin
      if (stall_evt && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_evt && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
      case (state)
        RUN: begin
          if (h) begin
            if (hz.EX_BR_TAKEN) begin
              state    <= PEND;
              target_q <= hz.EX_TA;
            end else begin
              state <= STALL;
            end
          end
        end
        STALL, PEND: if (!h) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign hz.STALL_CNT = stall_cnt;
  assign hz.FLUSH_CNT = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: single-cycle vector table through a scoreboard queue,
// then hand-written multi-cycle sequences for stall, pending redirect and reset corner cases.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0]  ra, rb;
    logic        ua, ub;
    logic [4:0]  exd, memd, wbd;
    logic        exle, memle, wble, exl, br, nul;
    logic [31:0] ta;
  } stim_t;

  typedef struct packed {
    logic        pc_le, ifid_le, clr, bub, ta_sel;
    logic [1:0]  fa, fb;
    logic [31:0] pct;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam stim_t S_IDLE = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
  localparam exp_t EXP_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
  localparam exp_t EXP_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0};
  localparam exp_t EXP_RST   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0};

  logic clk;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  vec_t tbl[13];

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .Reset (Reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input stim_t s);
    hz.ID_RA       = s.ra;
    hz.ID_RB       = s.rb;
    hz.ID_USE_A    = s.ua;
    hz.ID_USE_B    = s.ub;
    hz.EX_RD       = s.exd;
    hz.MEM_RD      = s.memd;
    hz.WB_RD       = s.wbd;
    hz.EX_RF_LE    = s.exle;
    hz.MEM_RF_LE   = s.memle;
    hz.WB_RF_LE    = s.wble;
    hz.EX_L        = s.exl;
    hz.EX_BR_TAKEN = s.br;
    hz.EX_NULLIFY  = s.nul;
    hz.EX_TA       = s.ta;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input exp_t e, input bit chk_pct);
    check({tag, ".PC_LE"},     32'(hz.PC_LE),     32'(e.pc_le));
    check({tag, ".IF_ID_LE"},  32'(hz.IF_ID_LE),  32'(e.ifid_le));
    check({tag, ".IF_ID_CLR"}, 32'(hz.IF_ID_CLR), 32'(e.clr));
    check({tag, ".CU_BUBBLE"}, 32'(hz.CU_BUBBLE), 32'(e.bub));
    check({tag, ".TA_SEL"},    32'(hz.TA_SEL),    32'(e.ta_sel));
    check({tag, ".FWD_A"},     32'(hz.FWD_A),     32'(e.fa));
    check({tag, ".FWD_B"},     32'(hz.FWD_B),     32'(e.fb));
    if (chk_pct) check({tag, ".PC_TARGET"}, hz.PC_TARGET, e.pct);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    apply_stimulus(S_IDLE);
    step();
    Reset = 1'b0;
  endtask

  initial begin
    stim_t s;
    exp_t  e;

    tbl[0]  = '{"idle",     S_IDLE, EXP_RUN};
    tbl[1]  = '{"gr0",      '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}, EXP_RUN};
    tbl[2]  = '{"use_off",  '{5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}, EXP_RUN};
    tbl[3]  = '{"le_off",   '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}, EXP_RUN};
    tbl[4]  = '{"ex_alu",   '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}, EXP_STALL};
    tbl[5]  = '{"mem_b",    '{5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}, EXP_STALL};
    tbl[6]  = '{"wb_a",     '{5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}, EXP_STALL};
    tbl[7]  = '{"prio",     '{5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}, EXP_STALL};
    tbl[8]  = '{"load_use", '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0}, EXP_STALL};
    tbl[9]  = '{"branch",   '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000},
                '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 32'h1000}};
    tbl[10] = '{"nullify",  '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0},
                '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0}};
    tbl[11] = '{"nul_br",   '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000},
                '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 32'h2000}};
    tbl[12] = '{"br_haz",   '{5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3000}, EXP_STALL};
`ifdef HAZ_FORWARDING_EN
    tbl[4].e = EXP_RUN; tbl[4].e.fa = 2'b01;
    tbl[5].e = EXP_RUN; tbl[5].e.fb = 2'b10;
    tbl[6].e = EXP_RUN; tbl[6].e.fa = 2'b11;
    tbl[7].e = EXP_RUN; tbl[7].e.fa = 2'b01;
    tbl[8].e.fa = 2'b10;
`endif

    Reset = 1'b1;
    apply_stimulus(S_IDLE);
    step();
    check_output("reset", EXP_RST, 1'b1);
    check("reset.STALL_CNT", 32'(hz.STALL_CNT), 32'd0);
    check("reset.FLUSH_CNT", 32'(hz.FLUSH_CNT), 32'd0);
    s = tbl[6].s; s.br = 1'b1; s.ta = 32'h5555;
    apply_stimulus(s);
    #1;
    check_output("reset_busy", EXP_RST, 1'b1);

    for (int i = 0; i < 13; i++) begin
      do_reset();
      apply_stimulus(tbl[i].s);
      exp_q.push_back(tbl[i].e);
      #1;
      e = exp_q.pop_front();
      check_output(tbl[i].name, e, e.ta_sel);
    end

    // Register-dependency stall through the pipeline (mode-specific).
    do_reset();
`ifdef HAZ_FORWARDING_EN
    s = S_IDLE; s.ra = 5'd5; s.ua = 1'b1; s.exd = 5'd5; s.exle = 1'b1; s.exl = 1'b1;
    apply_stimulus(s); #1;
    check("lu1.CU_BUBBLE", 32'(hz.CU_BUBBLE), 32'd1);
    check("lu1.PC_LE",     32'(hz.PC_LE),     32'd0);
    step();
    s.exle = 1'b0; s.exl = 1'b0; s.memd = 5'd5; s.memle = 1'b1;
    apply_stimulus(s); #1;
    check("lu2.FWD_A",     32'(hz.FWD_A),     32'd2);
    check("lu2.PC_LE",     32'(hz.PC_LE),     32'd1);
    check("lu2.CU_BUBBLE", 32'(hz.CU_BUBBLE), 32'd0);
    check("lu2.STALL_CNT", 32'(hz.STALL_CNT), 32'd1);
    step();
    check("lu3.STALL_CNT", 32'(hz.STALL_CNT), 32'd1);
`else
    s = S_IDLE; s.rb = 5'd7; s.ub = 1'b1; s.exd = 5'd7; s.exle = 1'b1;
    apply_stimulus(s); #1;
    check("wb1.CU_BUBBLE", 32'(hz.CU_BUBBLE), 32'd1);
    check("wb1.PC_LE",     32'(hz.PC_LE),     32'd0);
    step();
    s.exle = 1'b0; s.memd = 5'd7; s.memle = 1'b1;
    apply_stimulus(s); #1;
    check("wb2.CU_BUBBLE", 32'(hz.CU_BUBBLE), 32'd1);
    check("wb2.STALL_CNT", 32'(hz.STALL_CNT), 32'd1);
    step();
    s.memle = 1'b0; s.wbd = 5'd7; s.wble = 1'b1;
    apply_stimulus(s); #1;
    check("wb3.IF_ID_LE",  32'(hz.IF_ID_LE),  32'd0);
    check("wb3.STALL_CNT", 32'(hz.STALL_CNT), 32'd2);
    step();
    s.wble = 1'b0;
    apply_stimulus(s); #1;
    check_output("wb4", EXP_RUN, 1'b0);
    check("wb4.STALL_CNT", 32'(hz.STALL_CNT), 32'd3);
    step();
    check("wb5.STALL_CNT", 32'(hz.STALL_CNT), 32'd3);
`endif

    do_reset();
    s = S_IDLE; s.br = 1'b1; s.ta = 32'h1000;
    apply_stimulus(s); #1;
    check_output("br1", '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 32'h1000}, 1'b1);
    step();
    apply_stimulus(S_IDLE); #1;
    check("br2.FLUSH_CNT", 32'(hz.FLUSH_CNT), 32'd1);
    check("br2.TA_SEL",    32'(hz.TA_SEL),    32'd0);

    // Taken branch colliding with a load-use stall: redirect waits with the latched target.
    do_reset();
    s = S_IDLE; s.ra = 5'd5; s.ua = 1'b1; s.exd = 5'd5; s.exle = 1'b1; s.exl = 1'b1;
    s.br = 1'b1; s.ta = 32'h1000;
    apply_stimulus(s); #1;
    check_output("pend1", EXP_STALL, 1'b0);
    step();
    s.br = 1'b0; s.ta = 32'hDEAD_BEEF;
    apply_stimulus(s); #1;
    check_output("pend2", EXP_STALL, 1'b0);
    check("pend2.STALL_CNT", 32'(hz.STALL_CNT), 32'd1);
    step();
    s = S_IDLE; s.ta = 32'hDEAD_BEEF;
    apply_stimulus(s); #1;
    check_output("pend3", '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 32'h1000}, 1'b1);
    check("pend3.STALL_CNT", 32'(hz.STALL_CNT), 32'd2);
    check("pend3.FLUSH_CNT", 32'(hz.FLUSH_CNT), 32'd0);
    step();
    apply_stimulus(S_IDLE); #1;
    check_output("pend4", EXP_RUN, 1'b0);
    check("pend4.FLUSH_CNT", 32'(hz.FLUSH_CNT), 32'd1);

    // Once stalled, branch and nullify from EX are ignored.
    do_reset();
    s = S_IDLE; s.ra = 5'd5; s.ua = 1'b1; s.exd = 5'd5; s.exle = 1'b1; s.exl = 1'b1;
    apply_stimulus(s);
    step();
    s.nul = 1'b1; s.br = 1'b1; s.ta = 32'h4000;
    apply_stimulus(s); #1;
    check_output("stl1", EXP_STALL, 1'b0);
    step();
    s = S_IDLE; s.br = 1'b1; s.ta = 32'h4000;
    apply_stimulus(s); #1;
    check_output("stl2", EXP_RUN, 1'b0);
    step();
    check_output("stl3", '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 32'h4000}, 1'b1);
    step();
    check("stl4.FLUSH_CNT", 32'(hz.FLUSH_CNT), 32'd1);
    check("stl4.STALL_CNT", 32'(hz.STALL_CNT), 32'd2);

    do_reset();
    s = S_IDLE; s.ra = 5'd5; s.ua = 1'b1; s.exd = 5'd5; s.exle = 1'b1; s.exl = 1'b1; s.nul = 1'b1;
    apply_stimulus(s); #1;
    check_output("nul1", '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0}, 1'b0);
    step();
    apply_stimulus(S_IDLE); #1;
    check_output("nul2", EXP_RUN, 1'b0);
    check("nul2.STALL_CNT", 32'(hz.STALL_CNT), 32'd0);

    // Reset while a redirect is pending drops it.
    s = S_IDLE; s.ra = 5'd5; s.ua = 1'b1; s.exd = 5'd5; s.exle = 1'b1; s.exl = 1'b1;
    s.br = 1'b1; s.ta = 32'h1000;
    apply_stimulus(s);
    step();
    Reset = 1'b1;
    #1;
    check_output("rstp1", EXP_RST, 1'b1);
    step();
    Reset = 1'b0;
    apply_stimulus(S_IDLE); #1;
    check_output("rstp2", EXP_RUN, 1'b0);
    check("rstp2.STALL_CNT", 32'(hz.STALL_CNT), 32'd0);
    check("rstp2.FLUSH_CNT", 32'(hz.FLUSH_CNT), 32'd0);
    step();
    check("rstp3.FLUSH_CNT", 32'(hz.FLUSH_CNT), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
